// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep memory-port controller.
// Operand bundle, widths and FSM state encodings.
package lockstep_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } operand_t;

    localparam int OP_WIDTH = $bits(operand_t);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_PEER = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_ISSUE     = 3'd3;
    localparam logic [2:0] ST_RECOVER   = 3'd4;
    localparam logic [2:0] ST_FATAL     = 3'd5;

endpackage

// File: rtl/lockstep_write_ctrl_cmp.sv
// Lockstep operand comparator.
// Flags any difference between the two latched core requests.
module lockstep_write_ctrl_cmp
    import lockstep_pkg::*;
(
    input  logic [OP_WIDTH-1:0] op_a,
    input  logic [OP_WIDTH-1:0] op_b,
    output logic                mismatch
);

    assign mismatch = (op_a != op_b);

endmodule

// File: rtl/lockstep_write_ctrl.sv
// Dual-core lockstep memory port sequencer.
// Pairs core requests, compares them, commits or rolls back.
module lockstep_write_ctrl
    import lockstep_pkg::*;
#(
    parameter int SKEW_TIMEOUT  = 15,
    parameter int MAX_RETRY     = 3,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_a_i,
    input  logic                     req_b_i,
    input  logic                     we_a_i,
    input  logic                     we_b_i,
    input  logic [ADDR_WIDTH-1:0]    addr_a_i,
    input  logic [ADDR_WIDTH-1:0]    addr_b_i,
    input  logic [DATA_WIDTH-1:0]    data_a_i,
    input  logic [DATA_WIDTH-1:0]    data_b_i,
    output logic                     gnt_a_o,
    output logic                     gnt_b_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_WIDTH-1:0]    mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_gnt_i,
    output logic                     recover_o,
    input  logic                     recover_done_i,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic                     fatal_o
);

    localparam int SKEW_W  = $clog2(SKEW_TIMEOUT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [SKEW_W-1:0]        SKEW_ONE  = 1;
    localparam logic [SKEW_W-1:0]        SKEW_MAX  = SKEW_TIMEOUT;
    localparam logic [RETRY_W-1:0]       RETRY_ONE = 1;
    localparam logic [RETRY_W-1:0]       RETRY_MAX = MAX_RETRY;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE   = 1;

    logic [2:0]               state;
    operand_t                 op_a;
    operand_t                 op_b;
    operand_t                 in_a;
    operand_t                 in_b;
    logic                     lone_a;
    logic [SKEW_W-1:0]        skew;
    logic [RETRY_W-1:0]       retry;
    logic [RETRY_W-1:0]       retry_nxt;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    logic                     gnt;
    logic                     mismatch;
    logic                     both;
    logic                     lone_gone;
    logic                     fail;

    assign in_a = '{we: we_a_i, addr: addr_a_i, data: data_a_i};
    assign in_b = '{we: we_b_i, addr: addr_b_i, data: data_b_i};

    lockstep_write_ctrl_cmp u_cmp (
        .op_a     (op_a),
        .op_b     (op_b),
        .mismatch (mismatch)
    );

    assign both      = req_a_i & req_b_i;
    assign lone_gone = lone_a ? !req_a_i : !req_b_i;
    assign retry_nxt = retry + RETRY_ONE;

    // A timeout only counts if the peer is still absent and the lone core still waits
    assign fail = ((state == ST_WAIT_PEER) && !both && !lone_gone
                   && (skew == SKEW_MAX))
                | ((state == ST_CHECK) && mismatch);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            op_a    <= '0;
            op_b    <= '0;
            lone_a  <= 1'b0;
            skew    <= '0;
            retry   <= '0;
            err_cnt <= '0;
            gnt     <= 1'b0;
        end else begin
            gnt <= 1'b0;
            if (fail) begin
                err_cnt <= (&err_cnt) ? err_cnt : err_cnt + ERR_ONE;
                retry   <= retry_nxt;
                state   <= (retry_nxt >= RETRY_MAX) ? ST_FATAL : ST_RECOVER;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        // Cores still hold req during the grant cycle
                        if (!gnt) begin
                            if (both) begin
                                op_a  <= in_a;
                                op_b  <= in_b;
                                state <= ST_CHECK;
                            end else if (req_a_i || req_b_i) begin
                                lone_a <= req_a_i;
                                skew   <= SKEW_ONE;
                                state  <= ST_WAIT_PEER;
                            end
                        end
                    end
                    ST_WAIT_PEER: begin
                        if (both) begin
                            op_a  <= in_a;
                            op_b  <= in_b;
                            state <= ST_CHECK;
                        end else if (lone_gone) begin
                            state <= ST_IDLE;
                        end else begin
                            skew <= skew + SKEW_ONE;
                        end
                    end
                    ST_CHECK: begin
                        state <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (mem_gnt_i) begin
                            gnt   <= 1'b1;
                            retry <= '0;
                            state <= ST_IDLE;
                        end
                    end
                    ST_RECOVER: begin
                        if (recover_done_i) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_FATAL: begin
                        state <= ST_FATAL;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req_o   = (state == ST_ISSUE);
    assign mem_we_o    = mem_req_o & op_a.we;
    assign mem_addr_o  = mem_req_o ? op_a.addr : '0;
    assign mem_wdata_o = mem_req_o ? op_a.data : '0;
    assign gnt_a_o     = gnt;
    assign gnt_b_o     = gnt;
    assign recover_o   = (state == ST_RECOVER);
    assign fatal_o     = (state == ST_FATAL);
    assign err_count_o = err_cnt;

endmodule
